// File: rtl/ext_int_arbiter.sv
// ext_int_arbiter: external-interrupt gateway and two-context (M/S) arbiter.
// Each source is latched into PENDING and stays closed until it is claimed and
// then completed. The best eligible source per context drives a registered
// claim ID, and its priority compared against the context threshold drives
// MEIP/SEIP.
// Optional feature macro: IRQ_EDGE_EN adds per-source edge triggering (TrigEdge)
// with a one-deep re-request bit.
module ext_int_arbiter #(
  parameter int NSRC  = 8,
  parameter int PRIOW = 3,
  localparam int IDW  = $clog2(NSRC + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  IrqSrc,
`ifdef IRQ_EDGE_EN
  input  logic [NSRC-1:0]  TrigEdge,
`endif
  input  logic             PrioWrEn,
  input  logic [IDW-1:0]   PrioWrId,
  input  logic [PRIOW-1:0] PrioWrData,
  input  logic [NSRC-1:0]  EnM,
  input  logic [NSRC-1:0]  EnS,
  input  logic [PRIOW-1:0] ThreshM,
  input  logic [PRIOW-1:0] ThreshS,
  input  logic             ClaimM,
  input  logic             ClaimS,
  input  logic             CompleteEn,
  input  logic [IDW-1:0]   CompleteId,
  output logic [IDW-1:0]   ClaimIdM,
  output logic [IDW-1:0]   ClaimIdS,
  output logic             MExtIntOut,
  output logic             SExtIntOut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_INSV = 2'd2
  } src_state_e;

  src_state_e       state_q [NSRC];
  src_state_e       state_d [NSRC];
  logic [PRIOW-1:0] prio_q  [NSRC];

  logic [IDW-1:0]   claim_m_q, claim_s_q;
  logic             meip_q, seip_q;

  logic [IDW-1:0]   best_m_id, best_s_id;
  logic [PRIOW-1:0] best_m_pr, best_s_pr;

  logic [NSRC-1:0]  req_w;
  logic [NSRC-1:0]  claim_hit;
  logic [NSRC-1:0]  cmpl_hit;
  logic             claim_s_ok;
  logic             claim_clash;

`ifdef IRQ_EDGE_EN
  logic [NSRC-1:0]  irq_prev_q;
  logic [NSRC-1:0]  again_q, again_d;
  logic [NSRC-1:0]  rise_w;

  // Edge sources request only on a rising edge; level sources on the level
  always_comb begin
    rise_w = IrqSrc & ~irq_prev_q;
    req_w  = (TrigEdge & rise_w) | (~TrigEdge & IrqSrc);
  end
`else
  // All sources are level-triggered
  always_comb begin
    req_w = IrqSrc;
  end
`endif

  // Highest-priority eligible source per context; strict compare keeps the lowest ID on ties
  always_comb begin
    best_m_id = '0;
    best_m_pr = '0;
    best_s_id = '0;
    best_s_pr = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (state_q[i] == S_PEND && EnM[i] && prio_q[i] > best_m_pr) begin
        best_m_pr = prio_q[i];
        best_m_id = IDW'(i + 1);
      end
      if (state_q[i] == S_PEND && EnS[i] && prio_q[i] > best_s_pr) begin
        best_s_pr = prio_q[i];
        best_s_id = IDW'(i + 1);
      end
    end
  end

  // Decode claim/complete strobes per source; M wins when both contexts claim the same ID
  always_comb begin
    claim_clash = ClaimM && ClaimS && (claim_m_q == claim_s_q);
    claim_s_ok  = ClaimS && !claim_clash;
    claim_hit   = '0;
    cmpl_hit    = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_hit[i] = (ClaimM && claim_m_q == IDW'(i + 1)) ||
                     (claim_s_ok && claim_s_q == IDW'(i + 1));
      cmpl_hit[i]  = CompleteEn && (CompleteId == IDW'(i + 1));
    end
  end

  // Per-source gateway next state
  always_comb begin
`ifdef IRQ_EDGE_EN
    again_d = again_q;
`endif
    for (int i = 0; i < NSRC; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_IDLE:  if (req_w[i])     state_d[i] = S_PEND;
        S_PEND:  if (claim_hit[i]) state_d[i] = S_INSV;
        S_INSV:  if (cmpl_hit[i])  state_d[i] = S_IDLE;
        default: state_d[i] = S_IDLE;
      endcase
`ifdef IRQ_EDGE_EN
      // A remembered (or simultaneous) edge re-arms the source straight to PENDING on complete
      if (state_q[i] == S_INSV && cmpl_hit[i]) begin
        again_d[i] = 1'b0;
        if (TrigEdge[i] && (again_q[i] || rise_w[i])) state_d[i] = S_PEND;
      end else if (state_q[i] != S_IDLE && TrigEdge[i] && rise_w[i]) begin
        again_d[i] = 1'b1;
      end
`endif
    end
  end

  // Source state, priorities and registered arbitration results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSRC; i++) begin
        state_q[i] <= S_IDLE;
        prio_q[i]  <= '0;
      end
      claim_m_q <= '0;
      claim_s_q <= '0;
      meip_q    <= 1'b0;
      seip_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        state_q[i] <= state_d[i];
        if (PrioWrEn && PrioWrId == IDW'(i + 1)) prio_q[i] <= PrioWrData;
      end
      claim_m_q <= best_m_id;
      claim_s_q <= best_s_id;
      meip_q    <= (best_m_pr > ThreshM);
      seip_q    <= (best_s_pr > ThreshS);
    end
  end

`ifdef IRQ_EDGE_EN
  // Previous request level and re-request bits for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev_q <= '0;
      again_q    <= '0;
    end else begin
      irq_prev_q <= IrqSrc;
      again_q    <= again_d;
    end
  end
`endif

  // S sees 0 in a cycle where M takes the same ID
  always_comb begin
    ClaimIdM   = claim_m_q;
    ClaimIdS   = claim_clash ? '0 : claim_s_q;
    MExtIntOut = meip_q;
    SExtIntOut = seip_q;
  end

endmodule

// File: tb/tb_ext_int_arbiter.sv
// Bench for ext_int_arbiter: directed scenarios followed by random traffic,
// checked by a scoreboard against a behavioural model of the source states.
module tb_ext_int_arbiter;
  localparam int NSRC  = 8;
  localparam int PRIOW = 3;
  localparam int IDW   = $clog2(NSRC + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [NSRC-1:0]  IrqSrc;
  logic [NSRC-1:0]  TrigEdge;
  logic             PrioWrEn;
  logic [IDW-1:0]   PrioWrId;
  logic [PRIOW-1:0] PrioWrData;
  logic [NSRC-1:0]  EnM, EnS;
  logic [PRIOW-1:0] ThreshM, ThreshS;
  logic             ClaimM, ClaimS, CompleteEn;
  logic [IDW-1:0]   CompleteId;
  logic [IDW-1:0]   ClaimIdM, ClaimIdS;
  logic             MExtIntOut, SExtIntOut;

  always #5 clk = ~clk;

  ext_int_arbiter #(.NSRC(NSRC), .PRIOW(PRIOW)) dut (
    .clk(clk), .reset(reset), .IrqSrc(IrqSrc),
`ifdef IRQ_EDGE_EN
    .TrigEdge(TrigEdge),
`endif
    .PrioWrEn(PrioWrEn), .PrioWrId(PrioWrId), .PrioWrData(PrioWrData),
    .EnM(EnM), .EnS(EnS), .ThreshM(ThreshM), .ThreshS(ThreshS),
    .ClaimM(ClaimM), .ClaimS(ClaimS), .CompleteEn(CompleteEn), .CompleteId(CompleteId),
    .ClaimIdM(ClaimIdM), .ClaimIdS(ClaimIdS), .MExtIntOut(MExtIntOut), .SExtIntOut(SExtIntOut)
  );

  typedef struct {
    int idm;
    int ids;
    bit mext;
    bit sext;
  } exp_t;

  exp_t expq[$];
  int   nvec = 0;
  int   nerr = 0;

  // Reference model: 0 idle, 1 pending, 2 in service
  int st   [1:NSRC];
  int pr   [1:NSRC];
  bit prev [1:NSRC];
  bit ra   [1:NSRC];
  int outM, outS;
  bit mext, sext;

  function automatic int best(input logic [NSRC-1:0] en);
    int b  = 0;
    int bp = 0;
    for (int id = 1; id <= NSRC; id++)
      if (st[id] == 1 && en[id-1] && pr[id] > bp) begin
        b  = id;
        bp = pr[id];
      end
    return b;
  endfunction

  function automatic int prio_of(input int id);
    return (id == 0) ? 0 : pr[id];
  endfunction

  task automatic model_reset();
    for (int id = 1; id <= NSRC; id++) begin
      st[id] = 0; pr[id] = 0; prev[id] = 0; ra[id] = 0;
    end
    outM = 0; outS = 0; mext = 0; sext = 0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven
  task automatic model_step();
    int  bm, bs;
    int  nst [1:NSRC];
    bit  is_edge, rise, claimed, cmp;
    bm = best(EnM);
    bs = best(EnS);
    for (int id = 1; id <= NSRC; id++) begin
      nst[id] = st[id];
      is_edge = 1'b0;
`ifdef IRQ_EDGE_EN
      is_edge = TrigEdge[id-1];
`endif
      rise    = IrqSrc[id-1] && !prev[id];
      claimed = (ClaimM && outM == id) ||
                (ClaimS && outS == id && !(ClaimM && outM == outS));
      cmp     = CompleteEn && (int'(CompleteId) == id);
      if (st[id] == 0) begin
        if (is_edge ? rise : IrqSrc[id-1]) nst[id] = 1;
      end else if (st[id] == 1) begin
        if (claimed) nst[id] = 2;
        if (is_edge && rise) ra[id] = 1;
      end else begin
        if (cmp) begin
          nst[id] = (is_edge && (ra[id] || rise)) ? 1 : 0;
          ra[id]  = 0;
        end else if (is_edge && rise) begin
          ra[id] = 1;
        end
      end
      prev[id] = IrqSrc[id-1];
    end
    mext = prio_of(bm) > int'(ThreshM);
    sext = prio_of(bs) > int'(ThreshS);
    outM = bm;
    outS = bs;
    if (PrioWrEn && PrioWrId >= 1 && PrioWrId <= NSRC) pr[PrioWrId] = int'(PrioWrData);
    for (int id = 1; id <= NSRC; id++) st[id] = nst[id];
  endtask

  // Inputs are already driven; record what the DUT must show this cycle, then take the edge
  task automatic run_cycle();
    exp_t e;
    e.idm  = outM;
    e.ids  = (ClaimM && ClaimS && outM == outS) ? 0 : outS;
    e.mext = mext;
    e.sext = sext;
    expq.push_back(e);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) run_cycle();
  endtask

  task automatic clr_strobes();
    PrioWrEn = 0; ClaimM = 0; ClaimS = 0; CompleteEn = 0;
  endtask

  task automatic set_prio(input int id, input int p);
    PrioWrEn = 1; PrioWrId = IDW'(id); PrioWrData = PRIOW'(p);
    run_cycle();
    PrioWrEn = 0;
  endtask

  task automatic check_zero(input string name);
    nvec++;
    if (ClaimIdM !== '0 || ClaimIdS !== '0 || MExtIntOut !== 1'b0 || SExtIntOut !== 1'b0) begin
      nerr++;
      $display("FAIL %s: got idM=%0d idS=%0d meip=%0b seip=%0b, required all 0",
               name, ClaimIdM, ClaimIdS, MExtIntOut, SExtIntOut);
    end
  endtask

  // Asynchronous reset in the middle of a cycle, held across one edge
  task automatic reset_mid(input string name);
    @(negedge clk);
    #1 reset = 1;
    #1 check_zero(name);
    model_reset();
    @(posedge clk);
    #1 reset = 0;
    clr_strobes();
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        nvec++;
        if (int'(ClaimIdM) != e.idm || int'(ClaimIdS) != e.ids ||
            MExtIntOut !== e.mext || SExtIntOut !== e.sext) begin
          nerr++;
          $display("FAIL vec%0d @%0t: got idM=%0d idS=%0d meip=%0b seip=%0b, required idM=%0d idS=%0d meip=%0b seip=%0b",
                   nvec, $time, ClaimIdM, ClaimIdS, MExtIntOut, SExtIntOut,
                   e.idm, e.ids, e.mext, e.sext);
        end
      end
    end
  end

  initial begin
    reset = 1; IrqSrc = '0; TrigEdge = '0; PrioWrId = '0; PrioWrData = '0;
    EnM = '0; EnS = '0; ThreshM = '0; ThreshS = '0; CompleteId = '0;
    clr_strobes();
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_zero("reset_state");
    reset = 0;

    // Single source reaches MEIP two cycles after it rises; S stays quiet
    set_prio(3, 2);
    EnM = '1; ThreshM = 0; IrqSrc[2] = 1;
    run_n(4);

    // Priority ordering, tie to lowest ID, claim and complete
    set_prio(2, 5); set_prio(6, 5); set_prio(4, 7);
    IrqSrc[1] = 1; IrqSrc[3] = 1; IrqSrc[5] = 1;
    run_n(3);
    ClaimM = 1; run_cycle(); ClaimM = 0;
    run_n(2);
    CompleteEn = 1; CompleteId = 4; run_cycle(); CompleteEn = 0;
    run_n(3);

    // Threshold gating
    reset_mid("reset_before_thresh");
    IrqSrc = '0; EnM = '1; ThreshM = 3;
    set_prio(5, 3);
    IrqSrc[4] = 1;
    run_n(3);
    ThreshM = 2;
    run_n(2);

    // Simultaneous claim from both contexts
    reset_mid("reset_before_dual");
    IrqSrc = '0; EnM = '1; EnS = '1; ThreshM = 0; ThreshS = 0;
    set_prio(1, 1);
    IrqSrc[0] = 1;
    run_n(3);
    ClaimM = 1; ClaimS = 1; run_cycle(); clr_strobes();
    run_n(3);

    // Ignored completes, then reset during a claim
    CompleteEn = 1; CompleteId = 7; run_cycle();
    CompleteId = 0; run_cycle(); CompleteEn = 0;
    CompleteEn = 1; CompleteId = 1; run_cycle(); CompleteEn = 0;
    run_n(3);
    ClaimM = 1;
    reset_mid("reset_mid_claim");

`ifdef IRQ_EDGE_EN
    // Edge source with a second pulse while in service
    IrqSrc = '0; TrigEdge = 8'h02; EnM = '1; ThreshM = 0;
    set_prio(2, 4);
    IrqSrc[1] = 1; run_cycle(); IrqSrc[1] = 0;
    run_n(2);
    ClaimM = 1; run_cycle(); ClaimM = 0;
    run_n(2);
    IrqSrc[1] = 1; run_cycle(); IrqSrc[1] = 0;
    run_n(2);
    CompleteEn = 1; CompleteId = 2; run_cycle(); CompleteEn = 0;
    run_n(3);
`endif

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if (c % 700 == 350) reset_mid("reset_random");
      if ($urandom_range(0, 3) == 0) IrqSrc = NSRC'($urandom);
`ifdef IRQ_EDGE_EN
      if ($urandom_range(0, 31) == 0) TrigEdge = NSRC'($urandom);
`endif
      PrioWrEn   = ($urandom_range(0, 5) == 0);
      PrioWrId   = IDW'($urandom_range(0, 15));
      PrioWrData = PRIOW'($urandom);
      if ($urandom_range(0, 15) == 0) EnM = NSRC'($urandom);
      if ($urandom_range(0, 15) == 0) EnS = NSRC'($urandom);
      if ($urandom_range(0, 15) == 0) ThreshM = PRIOW'($urandom);
      if ($urandom_range(0, 15) == 0) ThreshS = PRIOW'($urandom);
      ClaimM     = ($urandom_range(0, 3) == 0);
      ClaimS     = ($urandom_range(0, 3) == 0);
      CompleteEn = ($urandom_range(0, 2) == 0);
      CompleteId = ($urandom_range(0, 3) == 0) ? IDW'($urandom_range(0, 15))
                                               : IDW'($urandom_range(1, NSRC));
      run_cycle();
    end
    clr_strobes();

    repeat (3) @(posedge clk);
    if (expq.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: got %0d pending expectations, required 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
